pipe_skid_stage: RTL

- Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, a flush input and a saturating stall counter.
- Intended as the generic replacement for fixed per-stage flop banks (IF/ID, ID/EX, EX/MEM, MEM/WB): the stage payload is packed into one vector.
- The registered ready breaks the combinational backpressure path between stages.
- Flush kills in-flight entries on a branch/jump redirect.

---
 rtl/pipe_skid_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
//
// Generic pipeline stage register with a valid/ready handshake on both sides,
// a two-entry skid buffer, a synchronous flush and a saturating stall counter.
// The stage payload is carried as one packed DW-bit vector so the same block
// can stand in for any per-stage flop bank (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// The buffer holds up to two entries. The main register always drives
// out_data_o. The skid register catches the single beat that is already in
// flight when downstream stalls. Because of this, in_ready_o can be a
// registered signal, and no combinational ready path runs back through the
// pipeline.
//
// Parameters
//   DW        payload width in bits (>= 1)
//   RST_DATA  value loaded into the main and skid registers on reset
//   CNT_W     stall counter width in bits (>= 1)
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   flush_i      in   synchronous kill of every held entry
//   in_valid_i   in   upstream payload valid
//   in_ready_o   out  stage can accept (flop output)
//   in_data_i    in   upstream payload
//   out_valid_o  out  downstream payload valid (flop output)
//   out_ready_i  in   downstream accepts
//   out_data_o   out  downstream payload (main register)
//   occupancy_o  out  number of entries held: 0, 1 or 2
//   stall_cnt_o  out  saturating count of valid-but-not-ready cycles
// -----------------------------------------------------------------------------
module pipe_skid_stage #(
  parameter int unsigned     DW       = 128,
  parameter logic [DW-1:0]   RST_DATA = {DW{1'b0}},
  parameter int unsigned     CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DW-1:0]    in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DW-1:0]    out_data_o,
  output logic [1:0]       occupancy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // The state encoding is the occupancy value itself, so occupancy_o is a
  // direct flop output.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    main_q, main_d;
  logic [DW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic             stalled;

  // Handshake qualifiers. Both use the registered ready/valid, so these terms
  // never feed an output combinationally.
  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;
  assign stalled  = out_valid_q & ~out_ready_i;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      // Flush takes priority over everything else. An accept in this cycle is
      // discarded, and the data registers keep their old contents. The stage
      // no longer reports them as valid, so that stale data is never used.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data_i;
            state_d = ST_ONE;
          end
        end

        ST_ONE: begin
          unique case ({in_fire, out_fire})
            2'b11: main_d = in_data_i;        // streaming: replace in place
            2'b10: begin                      // downstream stalled: park the
              skid_d  = in_data_i;            // younger beat behind main
              state_d = ST_TWO;
            end
            2'b01: state_d = ST_EMPTY;
            default: ;
          endcase
        end

        ST_TWO: begin
          // in_ready is low here, so in_fire cannot happen. The skid entry is
          // the younger one and moves up into main once main is consumed.
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end

        default: state_d = ST_EMPTY;
      endcase
    end

    // Handshake flags are registered copies of the next-state decode. This
    // keeps in_ready_o and out_valid_o as pure flop outputs.
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // ---------------------------------------------------------------------------
  // Stall counter: counts backpressured cycles and saturates at its maximum.
  // Flush does not clear it; only reset does.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stalled && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= RST_DATA;
      skid_q      <= RST_DATA;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
